// File: rtl/open_list_pkg.sv
// rtl/open_list_pkg.sv - shared state encoding and sizing helper for the open list
// Contents:
//   ol_state_e   : batch sorter controller states
//   count_width  : bits needed to count 0..2*queue_size keys
package open_list_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } ol_state_e;

    function automatic int count_width(input int queue_size);
        return $clog2(2 * queue_size + 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - load/decrement/zero counter that spaces queue accesses
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : reload the counter with LOAD_VALUE
//   zero_o       : counter is 0 this cycle
//   expiring_o   : counter reaches 0 at the next edge unless reloaded
module settle_timer #(
    parameter int LOAD_VALUE = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic zero_o,
    output logic expiring_o
);

    localparam int W = (LOAD_VALUE < 1) ? 1 : $clog2(LOAD_VALUE + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Saturates at zero so an idle period never wraps the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(LOAD_VALUE);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o     = (cnt_q == '0);
    assign expiring_o = (cnt_q <= W'(1));

endmodule

// File: rtl/open_list_batch_sorter.sv
// rtl/open_list_batch_sorter.sv - fills the min-queue with a key batch, drains it in ascending order
// Ports:
//   CLK, RST                        : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last   : input key stream
//   m_valid/m_ready/m_data/m_last   : sorted output stream, smallest first
//   o_trunc                         : pulse when a batch is force-ended by a full queue
//   o_busy                          : low only when idle in FILL with no keys stored
//   q_wrt/q_read/q_node_f           : queue enqueue, dequeue and data input
//   q_full/q_empty/q_head           : queue status and current minimum
module open_list_batch_sorter
    import open_list_pkg::*;
#(
    parameter int QUEUE_SIZE    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  o_trunc,
    output logic                  o_busy,
    output logic                  q_wrt,
    output logic                  q_read,
    output logic [DATA_WIDTH-1:0] q_node_f,
    input  logic                  q_full,
    input  logic                  q_empty,
    input  logic [DATA_WIDTH-1:0] q_head
);

    localparam int CW = count_width(QUEUE_SIZE);

    ol_state_e             state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  trunc_q, trunc_d;
    logic                  settle_load, settle_zero, settle_expiring;
    logic                  s_hs, m_hs;

    settle_timer #(
        .LOAD_VALUE(SETTLE_CYCLES)
    ) u_settle (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (settle_load),
        .zero_o     (settle_zero),
        .expiring_o (settle_expiring)
    );

    assign s_hs = s_valid && s_ready;
    assign m_hs = m_valid_q && m_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        trunc_d     = 1'b0;
        settle_load = 1'b0;
        s_ready     = 1'b0;
        q_wrt       = 1'b0;
        q_read      = 1'b0;
        q_node_f    = s_data;

        if (m_hs) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                s_ready = !q_full;
                if (s_hs) begin
                    q_wrt   = 1'b1;
                    count_d = count_q + CW'(1);
                    if (s_last) begin
                        state_d     = SETTLE;
                        settle_load = 1'b1;
                    end
                end else if (q_full && count_q != '0) begin
                    // Queue is out of room mid-batch: sort what we have and leave
                    // the pending input key for the next batch.
                    trunc_d     = 1'b1;
                    state_d     = SETTLE;
                    settle_load = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_expiring) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q != '0 && q_empty) begin
                    // Queue lost keys we counted in: close the batch on whatever is held.
                    count_d  = '0;
                    m_last_d = m_valid_d;
                end else if (settle_zero && count_q != '0 && (!m_valid_q || m_ready)) begin
                    q_read      = 1'b1;
                    m_data_d    = q_head;
                    m_valid_d   = 1'b1;
                    m_last_d    = (count_q == CW'(1));
                    count_d     = count_q - CW'(1);
                    settle_load = 1'b1;
                end else if (count_q == '0 && !m_valid_q) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= FILL;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            trunc_q   <= trunc_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign o_trunc = trunc_q;
    assign o_busy  = !(state_q == FILL && count_q == '0);

endmodule

// File: tb/tb_open_list_batch_sorter.sv
// tb/tb_open_list_batch_sorter.sv - self-checking bench with a behavioural min-queue
module tb_open_list_batch_sorter;

    localparam int QS = 4;
    localparam int DW = 32;
    localparam int SC = 2;
    localparam logic [DW-1:0] ONES = '1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          o_trunc, o_busy, q_wrt, q_read;
    logic [DW-1:0] q_node_f;
    logic          q_full, q_empty;
    logic [DW-1:0] q_head;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    open_list_batch_sorter #(
        .QUEUE_SIZE(QS), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_trunc(o_trunc), .o_busy(o_busy),
        .q_wrt(q_wrt), .q_read(q_read), .q_node_f(q_node_f),
        .q_full(q_full), .q_empty(q_empty), .q_head(q_head)
    );

    // Behavioural min-queue: unordered storage, head is the minimum (all-ones when empty),
    // flags and head registered so they settle one cycle after an access.
    logic [DW-1:0] qmem[$];
    int            perr[$];

    function automatic logic [DW-1:0] qmin();
        logic [DW-1:0] m = ONES;
        foreach (qmem[i]) if (qmem[i] < m) m = qmem[i];
        return m;
    endfunction

    function automatic int qmin_idx();
        int idx = 0;
        foreach (qmem[i]) if (qmem[i] < qmem[idx]) idx = i;
        return idx;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            qmem.delete();
            q_full  <= 1'b0;
            q_empty <= 1'b1;
            q_head  <= ONES;
        end else begin
            if (q_wrt && q_read) perr.push_back(cyc);
            if (q_wrt) begin
                if (qmem.size() >= 2 * QS) perr.push_back(cyc);
                else qmem.push_back(q_node_f);
            end
            if (q_read) begin
                if (qmem.size() == 0) perr.push_back(cyc);
                else qmem.delete(qmin_idx());
            end
            q_full  <= (qmem.size() == 2 * QS);
            q_empty <= (qmem.size() == 0);
            q_head  <= qmin();
        end
    end

    // Event logs, sampled on the falling edge.
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_t[$];
    int            last_t[$];
    int            trunc_t[$];
    int            rd_t[$];

    always @(negedge CLK) begin
        if (!RST) begin
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                got_t.push_back(cyc);
            end
            if (s_valid && s_ready && s_last) last_t.push_back(cyc);
            if (o_trunc) trunc_t.push_back(cyc);
            if (q_read) rd_t.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        got_d.delete(); got_l.delete(); got_t.delete();
        last_t.delete(); trunc_t.delete(); rd_t.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_key(input logic [DW-1:0] k, input logic l);
        int w;
        w       = 0;
        s_valid = 1'b1;
        s_data  = k;
        s_last  = l;
        @(negedge CLK);
        while (!s_ready && w < 300) begin
            @(negedge CLK);
            w++;
        end
        if (!s_ready) chk("s_accept_timeout", 32'(s_ready), 32'd1);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int w;
        w = 0;
        while (got_d.size() < n && w < 400) begin
            @(negedge CLK);
            w++;
        end
        chk(name, got_d.size(), n);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_last"},  32'(m_last),  32'd0);
        chk({tag, "_m_data"},  m_data,       32'd0);
        chk({tag, "_o_trunc"}, 32'(o_trunc), 32'd0);
        chk({tag, "_o_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_q_wrt"},   32'(q_wrt),   32'd0);
        chk({tag, "_q_read"},  32'(q_read),  32'd0);
    endtask

    typedef struct {
        int                 n;
        logic [0:7][DW-1:0] keys;
        logic [0:7][DW-1:0] exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        RST     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        tbl[0].n    = 4;
        tbl[0].keys = {32'd7, 32'd3, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[0].exp  = {32'd1, 32'd3, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[1].n    = 1;
        tbl[1].keys = {32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[1].exp  = {32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[2].n    = 3;
        tbl[2].keys = {32'hFFFFFFFF, 32'd6, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[2].exp  = {32'd6, 32'd6, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[3].n    = 8;
        tbl[3].keys = {32'd10, 32'd2, 32'd8, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd5, 32'd3};
        tbl[3].exp  = {32'd0, 32'd2, 32'd2, 32'd3, 32'd5, 32'd8, 32'd10, 32'hFFFFFFFF};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_values("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick(2);

        // Table-driven batches with m_ready held high: order, m_last, latency, spacing.
        for (int v = 0; v < 4; v++) begin
            clear_logs();
            m_ready = 1'b1;
            for (int i = 0; i < tbl[v].n; i++) send_key(tbl[v].keys[i], i == tbl[v].n - 1);
            wait_outputs(tbl[v].n, "vec_count");
            tick(4);
            for (int i = 0; i < tbl[v].n && i < got_d.size(); i++) begin
                chk("vec_data", got_d[i], tbl[v].exp[i]);
                chk("vec_last", 32'(got_l[i]), 32'(i == tbl[v].n - 1));
            end
            if (got_t.size() > 0 && last_t.size() > 0)
                chk("vec_first_latency", got_t[0] - last_t[0], SC + 2);
            for (int i = 1; i < got_t.size(); i++)
                chk("vec_spacing", got_t[i] - got_t[i-1], SC + 1);
            chk("vec_trunc", trunc_t.size(), 0);
            chk("vec_reads", rd_t.size(), tbl[v].n);
            chk("vec_idle_busy", 32'(o_busy), 32'd0);
            chk("vec_idle_s_ready", 32'(s_ready), 32'd1);
        end

        // Output stall: head held stable, only one pop while blocked.
        begin
            int w;
            clear_logs();
            m_ready = 1'b0;
            send_key(32'd4, 1'b0);
            send_key(32'd2, 1'b1);
            w = 0;
            while (!m_valid && w < 50) begin
                @(negedge CLK);
                w++;
            end
            chk("stall_valid", 32'(m_valid), 32'd1);
            repeat (10) begin
                @(negedge CLK);
                chk("stall_hold_data", m_data, 32'd2);
                chk("stall_hold_valid", 32'(m_valid), 32'd1);
            end
            chk("stall_reads", rd_t.size(), 1);
            @(posedge CLK);
            #1;
            m_ready = 1'b1;
            wait_outputs(2, "stall_count");
            if (got_d.size() >= 2) begin
                chk("stall_data0", got_d[0], 32'd2);
                chk("stall_last0", 32'(got_l[0]), 32'd0);
                chk("stall_data1", got_d[1], 32'd4);
                chk("stall_last1", 32'(got_l[1]), 32'd1);
            end
            tick(4);
        end

        // Overflow: nine keys without s_last, the ninth starts the next batch.
        begin
            clear_logs();
            m_ready = 1'b1;
            for (int i = 0; i < 8; i++) send_key(32'(80 - 10 * i), 1'b0);
            send_key(32'd5, 1'b0);
            chk("trunc_pulses", trunc_t.size(), 1);
            chk("trunc_first_batch", got_d.size(), 8);
            send_key(32'd6, 1'b1);
            wait_outputs(10, "trunc_count");
            if (got_d.size() >= 10) begin
                for (int i = 0; i < 8; i++) begin
                    chk("trunc_data", got_d[i], 32'(10 * (i + 1)));
                    chk("trunc_last", 32'(got_l[i]), 32'(i == 7));
                end
                chk("trunc_next_data0", got_d[8], 32'd5);
                chk("trunc_next_last0", 32'(got_l[8]), 32'd0);
                chk("trunc_next_data1", got_d[9], 32'd6);
                chk("trunc_next_last1", 32'(got_l[9]), 32'd1);
            end
            tick(4);
        end

        // Randomized batches against a sorted reference, with m_ready toggling.
        for (int b = 0; b < 8; b++) begin
            int            n;
            bit            done;
            logic [DW-1:0] ks[$];
            logic [DW-1:0] ex[$];
            ks.delete();
            n = $urandom_range(1, 2 * QS);
            for (int i = 0; i < n; i++)
                ks.push_back(($urandom_range(0, 7) == 0) ? ONES : 32'($urandom_range(0, 20)));
            ex = ks;
            ex.sort();
            clear_logs();
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < n; i++) send_key(ks[i], i == n - 1);
                    wait_outputs(n, "rnd_count");
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        m_ready = 1'($urandom_range(0, 1));
                        @(posedge CLK);
                        #1;
                    end
                    m_ready = 1'b1;
                end
            join
            for (int i = 0; i < n && i < got_d.size(); i++) begin
                chk("rnd_data", got_d[i], ex[i]);
                chk("rnd_last", 32'(got_l[i]), 32'(i == n - 1));
            end
            chk("rnd_trunc", trunc_t.size(), 0);
            tick(4);
        end

        // Reset in the middle of a drain discards the batch.
        begin
            clear_logs();
            m_ready = 1'b1;
            send_key(32'd30, 1'b0);
            send_key(32'd20, 1'b0);
            send_key(32'd10, 1'b1);
            wait_outputs(1, "rst_first_out");
            RST = 1'b1;
            @(negedge CLK);
            chk_reset_values("midrst");
            @(posedge CLK);
            #1;
            RST = 1'b0;
            clear_logs();
            tick(2);
            send_key(32'd8, 1'b1);
            wait_outputs(1, "rst_next_count");
            tick(20);
            chk("rst_only_one", got_d.size(), 1);
            if (got_d.size() >= 1) begin
                chk("rst_next_data", got_d[0], 32'd8);
                chk("rst_next_last", 32'(got_l[0]), 32'd1);
            end
            chk("rst_idle_busy", 32'(o_busy), 32'd0);
        end

        chk("queue_protocol", perr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
